dcpu16_alu_ctl: RTL and testbench
=================================

# dcpu16_alu_ctl

Issue controller that sequences the DCPU16 ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU's `ena`, `pha`, `opc` and operand inputs through a four-phase cycle. It collects the ALU result, overflow word and condition flag, returns them as a one-cycle response, and implements the DCPU16 "skip next instruction" rule after a failed IFx test. It sits between the instruction decoder and the ALU.

## Interface
Parameters:
- `SKIP_EN`, default 1: when 1, a failed IFx discards the next accepted op; when 0, IFx only reports `rsp_cc`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: controller can accept; a transfer occurs when `req_vld` and `req_rdy` are both high at a clock edge.
- `req_opc` in 4: basic opcode 0x0–0xF.
- `req_a` in 16: operand a.
- `req_b` in 16: operand b.
- `stall` in 1: external wait (memory); freezes the sequence.
- `alu_ena` out 1: ALU enable.
- `alu_pha` out 2: ALU phase.
- `alu_opc` out 4: latched opcode to the ALU.
- `alu_a`, `alu_b` out 16: latched operands to the ALU.
- `alu_r` in 16: ALU result register.
- `alu_o` in 16: ALU overflow register.
- `alu_cc` in 1: ALU condition flag.
- `rsp_vld` out 1: one-cycle response strobe.
- `rsp_r` out 16: result.
- `rsp_o` out 16: overflow word.
- `rsp_cc` out 1: condition result.
- `rsp_wb` out 1: write `rsp_r` to operand a.
- `rsp_owb` out 1: write `rsp_o` to O.
- `rsp_skp` out 1: this op was skipped.
- `rsp_err` out 1: opcode not supported by the ALU (0x5–0x8).

## Operation
- FSM has two states, IDLE and RUN, plus a 2-bit phase counter `ph`.
- IDLE:
  - `req_rdy = !stall`, `alu_ena = 0`, `alu_pha = 0`.
  - On transfer: latch opc/a/b into the `alu_*` registers, `ph <= 0`, go to RUN.
  - Capture `skp_now = skip_pend`, then clear `skip_pend`.
- RUN:
  - `req_rdy = 0`, `alu_pha = ph`.
  - `alu_ena = !stall && !skp_now`.
  - Each cycle with `!stall`, `ph` increments.
  - When `ph == 3` and `!stall`, go to IDLE and register the response.
- Response fields, registered:
  - `rsp_vld = 1`; `rsp_o = alu_o`; `rsp_cc = alu_cc`; `rsp_skp = skp_now`.
  - `rsp_err = (opc in 5..8) && !skp_now`.
  - `rsp_r = alu_r`, forced to 0 when `rsp_err` or `skp_now`.
  - `rsp_wb = !skp_now && opc in {0x1,0x2,0x3,0x4,0x9,0xA,0xB}`. JSR (0x0) is not written back; the decoder uses `rsp_r` as the target.
  - `rsp_owb = !skp_now && opc in {0x2,0x3,0x4}`.
- Skip rule:
  - At response of a non-skipped opc 0xC–0xF with `alu_cc == 0` and `SKIP_EN`, set `skip_pend`.
  - A skipped op never sets `skip_pend`, so there is no chaining.
  - A skipped op still occupies the full four phases, with `alu_ena` held 0, so ALU state (R, O, CC) is unchanged.
- Arithmetic is done by the ALU. The controller only latches and forwards; all widths are 16 bits.

## Timing
- Reset values:
  - `req_rdy` = 0 during reset, then 1 in IDLE.
  - `alu_ena` = 0, `alu_pha` = 0, `alu_opc` = 0, `alu_a` = 0, `alu_b` = 0.
  - All `rsp_*` = 0, `skip_pend` = 0, state = IDLE.
- Latency: request accepted at edge k.
  - pha0 is cycle k..k+1; the ALU samples at edge k+1.
  - pha3 is cycle k+3..k+4.
  - `rsp_vld` is high in cycle k+4..k+5 only, with `req_rdy` high in the same cycle.
  - Minimum issue interval: 5 cycles. Each stalled cycle adds exactly one cycle.
- Stall in pha0: `alu_ena` is 0, so the ALU does not update. pha0 repeats until `stall` drops.
- Stall in pha1–3: `ph` holds. `rsp_vld` is delayed; its value is unchanged.
- `alu_*` operands and opc are stable from the accepting edge until the next accepted request.
- `rsp_*` data fields hold their values until the next response. `rsp_vld` is a pulse.
- `rst` mid-RUN: return to IDLE next edge, with no response and `skip_pend` cleared.

## Test plan
- Reset, then ADD a=0xFFFF b=0x0002 → `rsp_vld` 5 cycles after accept with `rsp_r`=0x0001, `rsp_o`=0x0001, `rsp_wb`=1, `rsp_owb`=1.
- MUL a=0x1234 b=0x0100 with `stall` high 3 cycles during pha2 → response 8 cycles after accept, `rsp_r`=0x3400, `rsp_o`=0x0012; `alu_ena` high exactly once.
- IFE a=1 b=2, then SET b=0x55 → IFE gives `rsp_cc`=0, `rsp_wb`=0. SET gives `rsp_skp`=1, `rsp_wb`=0, `rsp_r`=0 and no `alu_ena` pulse. A third SET gives `rsp_r`=0x0055, `rsp_wb`=1.
- IFN 3,3 (cc=0), then skipped IFE, then XOR 0xF0F0,0x0FF0 → XOR not skipped, `rsp_r`=0xFF00; the same sequence with `SKIP_EN`=0 shows no skip.
- DIV opc 0x5 → `rsp_err`=1, `rsp_r`=0, `rsp_wb`=0.
- Assert `rst` in pha2 of an AND → no `rsp_vld`, all outputs at reset values, and a new request is accepted 1 cycle after `rst` drops.

Source files
------------

// File: rtl/dcpu16_alu_ctl.sv
// Purpose : issue controller that walks the DCPU16 ALU through its four phases for one op at a time.
// Latency : response strobe 4 edges after the accepting edge (5-cycle issue interval), +1 per stalled cycle.
// Backpr. : req_rdy only in IDLE with stall low; stall freezes the phase counter and gates alu_ena.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_vld/req_rdy             request handshake; req_opc/req_a/req_b carry the basic op
//   stall                       external wait, freezes the sequence for as long as it is high
//   alu_ena/alu_pha             ALU enable and phase
//   alu_opc/alu_a/alu_b         opcode and operands held for the ALU until the next accept
//   alu_r/alu_o/alu_cc          ALU result, overflow and condition flag
//   rsp_vld                     one-cycle response strobe
//   rsp_r/rsp_o/rsp_cc          result, overflow word, condition result
//   rsp_wb/rsp_owb              write rsp_r to operand a / write rsp_o to O
//   rsp_skp/rsp_err             op was skipped / opcode not handled by the ALU (0x5..0x8)
module dcpu16_alu_ctl #(
  parameter bit SKIP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [3:0]  req_opc,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        stall,
  output logic        alu_ena,
  output logic [1:0]  alu_pha,
  output logic [3:0]  alu_opc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic [15:0] alu_o,
  input  logic        alu_cc,
  output logic        rsp_vld,
  output logic [15:0] rsp_r,
  output logic [15:0] rsp_o,
  output logic        rsp_cc,
  output logic        rsp_wb,
  output logic        rsp_owb,
  output logic        rsp_skp,
  output logic        rsp_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic        skip_pend_q, skip_pend_d;
  logic        skp_now_q, skp_now_d;
  logic [3:0]  alu_opc_q, alu_opc_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [15:0] rsp_r_q, rsp_r_d;
  logic [15:0] rsp_o_q, rsp_o_d;
  logic        rsp_cc_q, rsp_cc_d;
  logic        rsp_wb_q, rsp_wb_d;
  logic        rsp_owb_q, rsp_owb_d;
  logic        rsp_skp_q, rsp_skp_d;
  logic        rsp_err_q, rsp_err_d;

  logic        xfer;
  logic        op_wb, op_owb, op_err, op_test;

  // Opcode classes of the latched op, used when the response is built.
  always_comb begin
    op_wb   = 1'b0;
    op_owb  = 1'b0;
    op_err  = 1'b0;
    op_test = 1'b0;
    case (alu_opc_q)
      4'h1, 4'h9, 4'hA, 4'hB: op_wb = 1'b1;
      4'h2, 4'h3, 4'h4: begin
        op_wb  = 1'b1;
        op_owb = 1'b1;
      end
      4'h5, 4'h6, 4'h7, 4'h8: op_err = 1'b1;
      4'hC, 4'hD, 4'hE, 4'hF: op_test = 1'b1;
      default: ;  // JSR: result goes back as the jump target, no write-back
    endcase
  end

  // Handshake and ALU strobes follow stall/rst combinationally so a stalled
  // cycle never lets the ALU advance and reset never lets a request in.
  assign req_rdy = (state_q == ST_IDLE) && !stall && !rst;
  assign alu_ena = (state_q == ST_RUN) && !stall && !skp_now_q && !rst;
  assign alu_pha = (state_q == ST_RUN) ? ph_q : 2'd0;
  assign xfer    = req_vld && req_rdy;

  assign alu_opc = alu_opc_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_r   = rsp_r_q;
  assign rsp_o   = rsp_o_q;
  assign rsp_cc  = rsp_cc_q;
  assign rsp_wb  = rsp_wb_q;
  assign rsp_owb = rsp_owb_q;
  assign rsp_skp = rsp_skp_q;
  assign rsp_err = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    skip_pend_d = skip_pend_q;
    skp_now_d   = skp_now_q;
    alu_opc_d   = alu_opc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_vld_d   = 1'b0;
    rsp_r_d     = rsp_r_q;
    rsp_o_d     = rsp_o_q;
    rsp_cc_d    = rsp_cc_q;
    rsp_wb_d    = rsp_wb_q;
    rsp_owb_d   = rsp_owb_q;
    rsp_skp_d   = rsp_skp_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          alu_opc_d   = req_opc;
          alu_a_d     = req_a;
          alu_b_d     = req_b;
          ph_d        = 2'd0;
          state_d     = ST_RUN;
          // A pending skip is consumed by exactly this op.
          skp_now_d   = skip_pend_q;
          skip_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          ph_d = ph_q + 2'd1;  // wraps 3 -> 0, so ph is back at 0 in IDLE
          if (ph_q == 2'd3) begin
            state_d   = ST_IDLE;
            rsp_vld_d = 1'b1;
            rsp_o_d   = alu_o;
            rsp_cc_d  = alu_cc;
            rsp_skp_d = skp_now_q;
            rsp_err_d = op_err && !skp_now_q;
            rsp_r_d   = (op_err || skp_now_q) ? 16'h0000 : alu_r;
            rsp_wb_d  = op_wb && !skp_now_q;
            rsp_owb_d = op_owb && !skp_now_q;
            // Only a real (non-skipped) failed IFx arms the skip; a skipped
            // IFx saw stale CC and must not chain.
            if (SKIP_EN && !skp_now_q && op_test && !alu_cc) begin
              skip_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ph_q        <= 2'd0;
      skip_pend_q <= 1'b0;
      skp_now_q   <= 1'b0;
      alu_opc_q   <= 4'h0;
      alu_a_q     <= 16'h0000;
      alu_b_q     <= 16'h0000;
      rsp_vld_q   <= 1'b0;
      rsp_r_q     <= 16'h0000;
      rsp_o_q     <= 16'h0000;
      rsp_cc_q    <= 1'b0;
      rsp_wb_q    <= 1'b0;
      rsp_owb_q   <= 1'b0;
      rsp_skp_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      skip_pend_q <= skip_pend_d;
      skp_now_q   <= skp_now_d;
      alu_opc_q   <= alu_opc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_r_q     <= rsp_r_d;
      rsp_o_q     <= rsp_o_d;
      rsp_cc_q    <= rsp_cc_d;
      rsp_wb_q    <= rsp_wb_d;
      rsp_owb_q   <= rsp_owb_d;
      rsp_skp_q   <= rsp_skp_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_dcpu16_alu_ctl.sv
// Purpose : directed-vector bench for dcpu16_alu_ctl with a behavioural DCPU16 ALU per instance.
// Latency : expects the response 5 cycles after accept, plus one per stalled cycle.
// Backpr. : drives stall directly; a second instance with SKIP_EN=0 runs in lockstep.
module tb_dcpu16_alu_ctl;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] o;
    logic        cc;
  } alu_st_t;

  logic        clk = 1'b0;
  logic        rst, req_vld, stall;
  logic [3:0]  req_opc;
  logic [15:0] req_a, req_b;

  logic        req_rdy, alu_ena, rsp_vld, rsp_cc, rsp_wb, rsp_owb, rsp_skp, rsp_err;
  logic [1:0]  alu_pha;
  logic [3:0]  alu_opc;
  logic [15:0] alu_a, alu_b, rsp_r, rsp_o;

  logic        req_rdy_ns, alu_ena_ns, rsp_vld_ns, rsp_cc_ns, rsp_wb_ns, rsp_owb_ns, rsp_skp_ns, rsp_err_ns;
  logic [1:0]  alu_pha_ns;
  logic [3:0]  alu_opc_ns;
  logic [15:0] alu_a_ns, alu_b_ns, rsp_r_ns, rsp_o_ns;

  alu_st_t m1, m2;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcpu16_alu_ctl #(.SKIP_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_opc(req_opc), .req_a(req_a), .req_b(req_b), .stall(stall),
    .alu_ena(alu_ena), .alu_pha(alu_pha), .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(m1.r), .alu_o(m1.o), .alu_cc(m1.cc),
    .rsp_vld(rsp_vld), .rsp_r(rsp_r), .rsp_o(rsp_o), .rsp_cc(rsp_cc),
    .rsp_wb(rsp_wb), .rsp_owb(rsp_owb), .rsp_skp(rsp_skp), .rsp_err(rsp_err)
  );

  dcpu16_alu_ctl #(.SKIP_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy_ns),
    .req_opc(req_opc), .req_a(req_a), .req_b(req_b), .stall(stall),
    .alu_ena(alu_ena_ns), .alu_pha(alu_pha_ns), .alu_opc(alu_opc_ns), .alu_a(alu_a_ns), .alu_b(alu_b_ns),
    .alu_r(m2.r), .alu_o(m2.o), .alu_cc(m2.cc),
    .rsp_vld(rsp_vld_ns), .rsp_r(rsp_r_ns), .rsp_o(rsp_o_ns), .rsp_cc(rsp_cc_ns),
    .rsp_wb(rsp_wb_ns), .rsp_owb(rsp_owb_ns), .rsp_skp(rsp_skp_ns), .rsp_err(rsp_err_ns)
  );

  // Behavioural ALU: evaluates on an enabled phase-2 cycle, holds otherwise.
  function automatic alu_st_t alu_eval(input logic [3:0] opc, input logic [15:0] a,
                                       input logic [15:0] b, input alu_st_t cur);
    alu_st_t     nx;
    logic [16:0] s;
    logic [31:0] p;
    nx = cur;
    s  = {1'b0, a} + {1'b0, b};
    p  = {16'h0000, a} * {16'h0000, b};
    case (opc)
      4'h0: nx.r = a;
      4'h1: nx.r = b;
      4'h2: begin nx.r = s[15:0]; nx.o = {15'd0, s[16]}; end
      4'h3: begin nx.r = a - b; nx.o = (a < b) ? 16'hFFFF : 16'h0000; end
      4'h4: begin nx.r = p[15:0]; nx.o = p[31:16]; end
      4'h9: nx.r = a & b;
      4'hA: nx.r = a | b;
      4'hB: nx.r = a ^ b;
      4'hC: nx.cc = (a == b);
      4'hD: nx.cc = (a != b);
      4'hE: nx.cc = (a > b);
      4'hF: nx.cc = ((a & b) != 16'h0000);
      default: ;
    endcase
    return nx;
  endfunction

  always @(posedge clk) begin
    if (rst) m1 <= '0;
    else if (alu_ena && alu_pha == 2'd2) m1 <= alu_eval(alu_opc, alu_a, alu_b, m1);
  end

  always @(posedge clk) begin
    if (rst) m2 <= '0;
    else if (alu_ena_ns && alu_pha_ns == 2'd2) m2 <= alu_eval(alu_opc_ns, alu_a_ns, alu_b_ns, m2);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Presents a request from a negedge and returns 1ns after the accepting edge.
  task automatic send(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    @(negedge clk);
    req_opc = opc;
    req_a   = a;
    req_b   = b;
    req_vld = 1'b1;
    while (!req_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) chk("send_timeout", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  // Counts negedges from the accept until rsp_vld, plus alu_ena activity on the way.
  task automatic wait_rsp(output int lat, output int ena_all, output int ena_ph2);
    lat = 0;
    ena_all = 0;
    ena_ph2 = 0;
    do begin
      @(negedge clk);
      lat++;
      if (alu_ena) ena_all++;
      if (alu_ena && alu_pha == 2'd2) ena_ph2++;
    end while (!rsp_vld && lat < 40);
    if (!rsp_vld) chk("rsp_timeout", 32'(rsp_vld), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, ea, e2;
    rst = 1'b1; req_vld = 1'b0; stall = 1'b0;
    req_opc = 4'h0; req_a = 16'h0000; req_b = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    chk("rst_ena_pha", 32'({alu_ena, alu_pha}), 32'd0);
    chk("rst_opnd", 32'({alu_opc, alu_a, alu_b}), 32'd0);
    chk("rst_rsp_ro", {rsp_r, rsp_o}, 32'd0);
    chk("rst_rsp_flags", 32'({rsp_vld, rsp_cc, rsp_wb, rsp_owb, rsp_skp, rsp_err}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", 32'(req_rdy), 32'd1);
    stall = 1'b1; #1;
    chk("idle_stall_rdy", 32'(req_rdy), 32'd0);
    stall = 1'b0; #1;

    // ADD with carry out
    send(4'h2, 16'hFFFF, 16'h0002);
    wait_rsp(lat, ea, e2);
    chk("add_lat", 32'(lat), 32'd5);
    chk("add_r", 32'(rsp_r), 32'h0001);
    chk("add_o", 32'(rsp_o), 32'h0001);
    chk("add_wb_owb_skp_err", 32'({rsp_wb, rsp_owb, rsp_skp, rsp_err}), 32'b1100);
    chk("add_rdy_at_rsp", 32'(req_rdy), 32'd1);
    chk("add_ena_cnt", 32'(ea), 32'd4);
    chk("add_ns_o", 32'(rsp_o_ns), 32'h0001);
    @(negedge clk);
    chk("add_vld_pulse", 32'(rsp_vld), 32'd0);
    chk("add_r_hold", 32'(rsp_r), 32'h0001);
    chk("add_opnd_hold", {alu_a, alu_b}, 32'hFFFF0002);

    // MUL with three stalled cycles in phase 2
    send(4'h4, 16'h1234, 16'h0100);
    fork
      begin
        @(posedge clk); @(posedge clk); #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
      wait_rsp(lat, ea, e2);
    join
    chk("mul_lat", 32'(lat), 32'd8);
    chk("mul_r", 32'(rsp_r), 32'h3400);
    chk("mul_o", 32'(rsp_o), 32'h0012);
    chk("mul_ena_ph2", 32'(e2), 32'd1);
    chk("mul_ena_cnt", 32'(ea), 32'd4);
    chk("mul_owb", 32'(rsp_owb), 32'd1);

    // Failed IFE skips the following SET
    send(4'hC, 16'h0001, 16'h0002);
    wait_rsp(lat, ea, e2);
    chk("ife_cc_wb_owb", 32'({rsp_cc, rsp_wb, rsp_owb}), 32'd0);
    chk("ife_ns_vld_rdy", 32'({rsp_vld_ns, req_rdy_ns}), 32'b11);
    send(4'h1, 16'h0000, 16'h0055);
    wait_rsp(lat, ea, e2);
    chk("set1_skp", 32'(rsp_skp), 32'd1);
    chk("set1_wb", 32'(rsp_wb), 32'd0);
    chk("set1_r", 32'(rsp_r), 32'h0000);
    chk("set1_no_ena", 32'(ea), 32'd0);
    chk("set1_ns_skp_r", 32'({rsp_skp_ns, rsp_r_ns}), 32'h0000_0055);
    send(4'h1, 16'h0000, 16'h0055);
    wait_rsp(lat, ea, e2);
    chk("set2_r", 32'(rsp_r), 32'h0055);
    chk("set2_wb_skp", 32'({rsp_wb, rsp_skp}), 32'b10);

    // IFN fails, IFE is skipped without chaining, XOR executes
    send(4'hD, 16'h0003, 16'h0003);
    wait_rsp(lat, ea, e2);
    chk("ifn_cc", 32'(rsp_cc), 32'd0);
    send(4'hC, 16'h0007, 16'h0007);
    wait_rsp(lat, ea, e2);
    chk("ife_skp", 32'(rsp_skp), 32'd1);
    chk("ife_skp_cc_stale", 32'(rsp_cc), 32'd0);
    chk("ife_ns_skp_cc", 32'({rsp_skp_ns, rsp_cc_ns}), 32'b01);
    send(4'hB, 16'hF0F0, 16'h0FF0);
    wait_rsp(lat, ea, e2);
    chk("xor_skp", 32'(rsp_skp), 32'd0);
    chk("xor_r", 32'(rsp_r), 32'hFF00);
    chk("xor_wb", 32'(rsp_wb), 32'd1);
    chk("xor_ns_r_wb", 32'({rsp_r_ns, rsp_wb_ns}), 32'h1FE01);

    // Unsupported opcode
    send(4'h5, 16'h000A, 16'h0002);
    wait_rsp(lat, ea, e2);
    chk("div_err", 32'(rsp_err), 32'd1);
    chk("div_r", 32'(rsp_r), 32'h0000);
    chk("div_wb_owb", 32'({rsp_wb, rsp_owb}), 32'd0);
    chk("div_ns_err_owb", 32'({rsp_err_ns, rsp_owb_ns}), 32'b10);

    // SUB underflow
    send(4'h3, 16'h0001, 16'h0002);
    wait_rsp(lat, ea, e2);
    chk("sub_ro", {rsp_r, rsp_o}, 32'hFFFF_FFFF);

    // Reset during phase 2 of an AND
    send(4'h9, 16'hFFFF, 16'h00FF);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_rdy_ena_pha", 32'({req_rdy, alu_ena, alu_pha}), 32'd0);
    chk("mrst_opnd", 32'({alu_opc, alu_a, alu_b}), 32'd0);
    chk("mrst_rsp_ro", {rsp_r, rsp_o}, 32'd0);
    chk("mrst_rsp_flags", 32'({rsp_vld, rsp_cc, rsp_wb, rsp_owb, rsp_skp, rsp_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_opc = 4'h1; req_a = 16'h0000; req_b = 16'h0077; req_vld = 1'b1;
    @(negedge clk);
    chk("mrst_release_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1 req_vld = 1'b0;
    wait_rsp(lat, ea, e2);
    chk("mrst_set_lat", 32'(lat), 32'd5);
    chk("mrst_set_r_wb", 32'({rsp_r, rsp_wb}), 32'h000EF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
